// File: rtl/sha3_digest_streamer.sv
// Captures the final Keccak state once per hash and streams its digest as WIDTH-bit words.
// Define SHA3_STREAM_FULL_STATE_EN to add s_full, which streams the whole 200-byte state.
module sha3_digest_streamer #(
    parameter int WIDTH   = 16,
    parameter int STATE_W = 1600
) (
    input  logic               ACLK,
    input  logic               ARESETn,
    input  logic [STATE_W-1:0] s_state,
    input  logic [1:0]         s_id,
`ifdef SHA3_STREAM_FULL_STATE_EN
    input  logic               s_full,
`endif
    input  logic               s_valid,
    output logic               s_ready,
    output logic [WIDTH-1:0]   m_data,
    output logic [WIDTH/8-1:0] m_keep,
    output logic               m_last,
    output logic [1:0]         m_id,
    output logic               m_valid,
    input  logic               m_ready
);
    localparam int B     = WIDTH / 8;
    localparam int CNT_W = $clog2(1600 / 8 + 1);
`ifdef SHA3_STREAM_FULL_STATE_EN
    localparam int CAP_BYTES = 200;
`else
    localparam int CAP_BYTES = 64;
`endif
    localparam int CAP_W = 8 * CAP_BYTES;

    generate
        if (WIDTH != 8 && WIDTH != 16 && WIDTH != 32 && WIDTH != 64) begin : g_bad_width
            $error("sha3_digest_streamer: WIDTH must be 8, 16, 32 or 64");
        end
        if (STATE_W != 1600) begin : g_bad_state
            $error("sha3_digest_streamer: STATE_W must be 1600");
        end
    endgenerate

    typedef enum logic {
        ST_IDLE,
        ST_STREAM
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   last_idx_q, last_idx_d;
    logic [B-1:0]       keep_tail_q, keep_tail_d;
    logic [1:0]         id_q, id_d;
    logic [CAP_W-1:0]   cap_q;
    logic               load, shift;
    logic [B-1:0]       keep_tail;
    int                 nbytes, nwords, tail;

`ifndef SHA3_STREAM_FULL_STATE_EN
    // Lanes beyond the longest digest are never streamed in this build.
    logic unused_state;
    assign unused_state = ^s_state[STATE_W-1:CAP_W];
`endif

    function automatic int digest_bytes(input logic [1:0] id);
        case (id)
            2'd0:    return 28;
            2'd1:    return 32;
            2'd2:    return 48;
            default: return 64;
        endcase
    endfunction

    // Output view: the current word is always the low bytes of the capture register.
    always_comb begin
        m_valid = (state_q == ST_STREAM);
        m_last  = m_valid && (cnt_q == last_idx_q);
        m_id    = id_q;
        m_keep  = '0;
        m_data  = '0;
        if (m_valid) begin
            m_keep = m_last ? keep_tail_q : '1;
        end
        for (int j = 0; j < B; j++) begin
            if (m_keep[B-1-j]) begin
                m_data[WIDTH-1-8*j -: 8] = cap_q[8*j +: 8];
            end
        end
    end

    // NOTE: every variable gets a default before any branch so no latch is inferred.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        last_idx_d  = last_idx_q;
        keep_tail_d = keep_tail_q;
        id_d        = id_q;
        load        = 1'b0;
        shift       = 1'b0;
        keep_tail   = '0;

        nbytes = digest_bytes(s_id);
`ifdef SHA3_STREAM_FULL_STATE_EN
        if (s_full) begin
            nbytes = 200;
        end
`endif
        nwords = (nbytes + B - 1) / B;
        tail   = nbytes - (nwords - 1) * B;
        for (int i = 0; i < B; i++) begin
            keep_tail[i] = (i >= B - tail);
        end

        s_ready = (state_q == ST_IDLE) || (m_valid && m_ready && m_last);

        if (state_q == ST_STREAM && m_ready) begin
            if (m_last) begin
                state_d = ST_IDLE;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
                shift = 1'b1;
            end
        end

        // A capture overrides the last-word return to IDLE, giving back-to-back streams.
        if (s_valid && s_ready) begin
            load        = 1'b1;
            state_d     = ST_STREAM;
            cnt_d       = '0;
            id_d        = s_id;
            last_idx_d  = CNT_W'(nwords - 1);
            keep_tail_d = keep_tail;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            last_idx_q  <= '0;
            keep_tail_q <= '0;
            id_q        <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            last_idx_q  <= last_idx_d;
            keep_tail_q <= keep_tail_d;
            id_q        <= id_d;
        end
    end

    // NOTE: the wide capture register has no reset; its contents only reach m_data behind m_keep.
    always_ff @(posedge ACLK) begin
        if (load) begin
            cap_q <= s_state[CAP_W-1:0];
        end else if (shift) begin
            cap_q <= cap_q >> WIDTH;
        end
    end

endmodule

// File: tb/tb_sha3_digest_streamer.sv
// Self-checking bench for sha3_digest_streamer: vector table, directed corner cases, random backpressure.
`timescale 1ns/1ps
module tb_sha3_digest_streamer;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic [1599:0] st;
    logic [1:0]    sid;

    logic        sv16, sr16, mv16, mr16, ml16;
    logic [15:0] md16;
    logic [1:0]  mk16, mid16;

    logic        sv64, sr64, mv64, mr64, ml64;
    logic [63:0] md64;
    logic [7:0]  mk64;
    logic [1:0]  mid64;

    int checks;
    int errors;

    sha3_digest_streamer #(.WIDTH(16)) u_d16 (
        .ACLK(clk), .ARESETn(rst_n), .s_state(st), .s_id(sid),
`ifdef SHA3_STREAM_FULL_STATE_EN
        .s_full(1'b0),
`endif
        .s_valid(sv16), .s_ready(sr16), .m_data(md16), .m_keep(mk16), .m_last(ml16),
        .m_id(mid16), .m_valid(mv16), .m_ready(mr16)
    );

    sha3_digest_streamer #(.WIDTH(64)) u_d64 (
        .ACLK(clk), .ARESETn(rst_n), .s_state(st), .s_id(sid),
`ifdef SHA3_STREAM_FULL_STATE_EN
        .s_full(1'b0),
`endif
        .s_valid(sv64), .s_ready(sr64), .m_data(md64), .m_keep(mk64), .m_last(ml64),
        .m_id(mid64), .m_valid(mv64), .m_ready(mr64)
    );

`ifdef SHA3_STREAM_FULL_STATE_EN
    logic        sv32, sr32, mv32, mr32, ml32;
    logic [31:0] md32;
    logic [3:0]  mk32;
    logic [1:0]  mid32;

    sha3_digest_streamer #(.WIDTH(32)) u_d32 (
        .ACLK(clk), .ARESETn(rst_n), .s_state(st), .s_id(sid), .s_full(1'b1),
        .s_valid(sv32), .s_ready(sr32), .m_data(md32), .m_keep(mk32), .m_last(ml32),
        .m_id(mid32), .m_valid(mv32), .m_ready(mr32)
    );
`endif

    typedef struct {
        logic [1:0] id;
        int         nw16;
        int         nw64;
        logic [7:0] keep64_last;
    } vec_t;

    vec_t vecs[4];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: digest byte k is byte k%8 of lane k/8.
    function automatic int nb_of(input logic [1:0] id);
        int tab[4] = '{28, 32, 48, 64};
        return tab[id];
    endfunction

    function automatic logic [7:0] state_byte(input logic [1599:0] s, input int k);
        int lane = k / 8;
        return s[64*lane + 8*(k%8) +: 8];
    endfunction

    function automatic logic [63:0] exp_word(input logic [1599:0] s, input int nb, input int bw, input int w);
        logic [63:0] r = '0;
        for (int j = 0; j < bw; j++) begin
            int k = w * bw + j;
            r = {r[55:0], (k < nb) ? state_byte(s, k) : 8'h00};
        end
        return r;
    endfunction

    function automatic logic [7:0] exp_keep(input int nb, input int bw, input int w);
        logic [7:0] r = '0;
        for (int j = 0; j < bw; j++) begin
            r = {r[6:0], (w * bw + j) < nb};
        end
        return r;
    endfunction

    function automatic logic [1599:0] mk_state(input logic [511:0] dig, input int nb);
        logic [1599:0] s;
        for (int i = 0; i < 25; i++) s[64*i +: 64] = {$urandom, $urandom};
        for (int k = 0; k < nb; k++) s[8*k +: 8] = dig[511-8*k -: 8];
        return s;
    endfunction

    task automatic capture16(input logic [1599:0] s, input logic [1:0] id);
        int cyc = 0;
        @(negedge clk);
        st = s; sid = id; sv16 = 1'b1; mr16 = 1'b0;
        #1;
        while (!sr16 && cyc < 50) begin
            @(negedge clk); cyc++; #1;
        end
        check("s_ready_capture16", 64'(sr16), 64'd1);
    endtask

    // mode 0: always ready, 1: one on / two off, 2: random ready plus ignored s_valid pulses.
    task automatic drain16(input logic [1599:0] s, input logic [1:0] id, input int mode, input int stop_at,
                           input bit b2b, input logic [1599:0] s_next, input logic [1:0] id_next,
                           output int nw, output logic [15:0] first_d, output logic [15:0] last_d);
        int nb     = nb_of(id);
        int exp_nw = (nb + 1) / 2;
        int cyc    = 0;
        bit done   = 1'b0;
        bit stop;
        nw = 0; first_d = '0; last_d = '0;
        while (!done && cyc < 2000 && nw <= exp_nw + 2) begin
            @(negedge clk);
            cyc++;
            sv16 = 1'b0;
            case (mode)
                0:       mr16 = 1'b1;
                1:       mr16 = (cyc % 3 == 1);
                default: mr16 = 1'($urandom_range(0, 1));
            endcase
            if (mode == 2 && !ml16 && $urandom_range(0, 1) == 1) begin
                sv16 = 1'b1; sid = 2'($urandom); st[63:0] = {$urandom, $urandom};
            end
            stop = (stop_at >= 0 && nw == stop_at);
            if (stop) mr16 = 1'b0;
            if (b2b && ml16 && mr16) begin
                st = s_next; sid = id_next; sv16 = 1'b1;
            end
            #1;
            check("m_valid_held", 64'(mv16), 64'd1);
            if (!mv16) begin
                done = 1'b1;
            end else begin
                check("m_data16", 64'(md16), exp_word(s, nb, 2, nw));
                check("m_keep16", 64'(mk16), 64'(exp_keep(nb, 2, nw)));
                check("m_last16", 64'(ml16), 64'(nw == exp_nw - 1));
                check("m_id16", 64'(mid16), 64'(id));
                check("s_ready16", 64'(sr16), 64'(mr16 && (nw == exp_nw - 1)));
                if (stop) begin
                    done = 1'b1;
                end else if (mr16) begin
                    if (nw == 0) first_d = md16;
                    last_d = md16;
                    nw++;
                    if (ml16) done = 1'b1;
                end
            end
        end
        if (!done) check("drain16_timeout", 64'(nw), 64'(exp_nw));
    endtask

    task automatic capture64(input logic [1599:0] s, input logic [1:0] id);
        int cyc = 0;
        @(negedge clk);
        st = s; sid = id; sv64 = 1'b1; mr64 = 1'b1;
        #1;
        while (!sr64 && cyc < 50) begin
            @(negedge clk); cyc++; #1;
        end
        check("s_ready_capture64", 64'(sr64), 64'd1);
    endtask

    task automatic drain64(input logic [1599:0] s, input logic [1:0] id,
                           output int nw, output logic [63:0] last_d, output logic [7:0] last_k);
        int nb     = nb_of(id);
        int exp_nw = (nb + 7) / 8;
        int cyc    = 0;
        bit done   = 1'b0;
        nw = 0; last_d = '0; last_k = '0;
        while (!done && cyc < 100) begin
            @(negedge clk);
            cyc++;
            sv64 = 1'b0;
            #1;
            check("m_valid64", 64'(mv64), 64'd1);
            if (!mv64) begin
                done = 1'b1;
            end else begin
                check("m_data64", md64, exp_word(s, nb, 8, nw));
                check("m_keep64", 64'(mk64), 64'(exp_keep(nb, 8, nw)));
                check("m_last64", 64'(ml64), 64'(nw == exp_nw - 1));
                last_d = md64; last_k = mk64;
                nw++;
                if (ml64) done = 1'b1;
            end
        end
        if (!done) check("drain64_timeout", 64'(nw), 64'(exp_nw));
    endtask

    initial begin
        logic [1599:0] s, s2;
        logic [15:0]   f16, l16;
        logic [63:0]   l64;
        logic [7:0]    k64;
        logic [1:0]    rid;
        int            nw;

        checks = 0; errors = 0;
        vecs[0] = '{2'd0, 14, 4, 8'hF0};
        vecs[1] = '{2'd1, 16, 4, 8'hFF};
        vecs[2] = '{2'd2, 24, 6, 8'hFF};
        vecs[3] = '{2'd3, 32, 8, 8'hFF};

        rst_n = 1'b1; st = '0; sid = '0;
        sv16 = 1'b0; mr16 = 1'b0; sv64 = 1'b0; mr64 = 1'b0;
`ifdef SHA3_STREAM_FULL_STATE_EN
        sv32 = 1'b0; mr32 = 1'b0;
`endif
        #2 rst_n = 1'b0;
        #1;
        check("rst_m_valid", 64'(mv16), 64'd0);
        check("rst_m_last", 64'(ml16), 64'd0);
        check("rst_m_data", 64'(md16), 64'd0);
        check("rst_m_keep", 64'(mk16), 64'd0);
        check("rst_m_id", 64'(mid16), 64'd0);
        check("rst_m_valid64", 64'(mv64), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk); #1;
        check("post_rst_s_ready", 64'(sr16), 64'd1);

        for (int i = 0; i < 4; i++) begin
            s = mk_state('0, 0);
            capture16(s, vecs[i].id);
            drain16(s, vecs[i].id, 0, -1, 1'b0, '0, 2'd0, nw, f16, l16);
            check("vec_nw16", 64'(nw), 64'(vecs[i].nw16));
            capture64(s, vecs[i].id);
            drain64(s, vecs[i].id, nw, l64, k64);
            check("vec_nw64", 64'(nw), 64'(vecs[i].nw64));
            check("vec_keep64_last", 64'(k64), 64'(vecs[i].keep64_last));
        end

        s = mk_state({256'ha7ffc6f8bf1ed76651c14756a061d662f580ff4de43b49fa82d80a4b80f8434a, 256'h0}, 32);
        capture16(s, 2'd1);
        drain16(s, 2'd1, 0, -1, 1'b0, '0, 2'd0, nw, f16, l16);
        check("sha256_nw", 64'(nw), 64'd16);
        check("sha256_first", 64'(f16), 64'h a7ff);
        check("sha256_last", 64'(l16), 64'h434a);
        @(negedge clk); #1;
        check("idle_after_last", 64'(mv16), 64'd0);

        s = mk_state({224'h6b4e03423667dbb73b6e15454f0eb1abd4597f9a1b078e3f5b5a6bc7, 288'h0}, 28);
        capture64(s, 2'd0);
        drain64(s, 2'd0, nw, l64, k64);
        check("sha224_64_nw", 64'(nw), 64'd4);
        check("sha224_64_last_hi", 64'(l64[63:32]), 64'h5b5a6bc7);
        check("sha224_64_keep", 64'(k64), 64'hF0);

        s = mk_state('0, 0);
        capture16(s, 2'd3);
        drain16(s, 2'd3, 1, -1, 1'b0, '0, 2'd0, nw, f16, l16);
        check("bp_handshakes", 64'(nw), 64'd32);

        s = mk_state('0, 0);
        s2 = mk_state('0, 0);
        capture16(s, 2'd1);
        drain16(s, 2'd1, 0, -1, 1'b1, s2, 2'd3, nw, f16, l16);
        check("b2b_first_nw", 64'(nw), 64'd16);
        drain16(s2, 2'd3, 0, -1, 1'b0, '0, 2'd0, nw, f16, l16);
        check("b2b_second_nw", 64'(nw), 64'd32);

        s = mk_state('0, 0);
        capture16(s, 2'd2);
        drain16(s, 2'd2, 0, 5, 1'b0, '0, 2'd0, nw, f16, l16);
        check("pre_reset_words", 64'(nw), 64'd5);
        rst_n = 1'b0;
        #1;
        check("midrst_m_valid", 64'(mv16), 64'd0);
        check("midrst_m_last", 64'(ml16), 64'd0);
        check("midrst_m_keep", 64'(mk16), 64'd0);
        check("midrst_m_data", 64'(md16), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("midrst_s_ready", 64'(sr16), 64'd1);
        check("midrst_m_id", 64'(mid16), 64'd0);
        s = mk_state('0, 0);
        capture16(s, 2'd0);
        drain16(s, 2'd0, 0, -1, 1'b0, '0, 2'd0, nw, f16, l16);
        check("after_rst_nw", 64'(nw), 64'd14);

        for (int r = 0; r < 6; r++) begin
            rid = 2'($urandom);
            s = mk_state('0, 0);
            capture16(s, rid);
            drain16(s, rid, 2, -1, 1'b0, '0, 2'd0, nw, f16, l16);
            check("rand_nw", 64'(nw), 64'((nb_of(rid) + 1) / 2));
        end

`ifdef SHA3_STREAM_FULL_STATE_EN
        begin
            int  w   = 0;
            int  cyc = 0;
            bit  done = 1'b0;
            s = mk_state('0, 0);
            @(negedge clk);
            st = s; sid = 2'd2; sv32 = 1'b1; mr32 = 1'b1;
            #1;
            check("full_s_ready", 64'(sr32), 64'd1);
            while (!done && cyc < 300) begin
                @(negedge clk);
                cyc++;
                sv32 = 1'b0;
                #1;
                check("full_m_valid", 64'(mv32), 64'd1);
                if (!mv32) begin
                    done = 1'b1;
                end else begin
                    check("full_m_data", 64'(md32), exp_word(s, 200, 4, w));
                    check("full_m_keep", 64'(mk32), 64'hF);
                    check("full_m_last", 64'(ml32), 64'(w == 49));
                    check("full_m_id", 64'(mid32), 64'd2);
                    w++;
                    if (ml32) done = 1'b1;
                end
            end
            check("full_nw", 64'(w), 64'd50);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sha3_digest_streamer.md
Name: sha3_digest_streamer

Overview:
Output-side serializer for the SHA3 core. It captures the final 1600-bit Keccak state once per hash and streams the digest as WIDTH-bit AXI-Stream-style words. The digest length is selected per hash by ID (SHA3-224/256/384/512). This generalises the fixed 16-bit Mode_out/Ready/Last output path with a parametrised width, per-ID digest length, partial-word TKEEP, TREADY backpressure and back-to-back capture. It sits between the permutation core and the AXI_SHA top-level output.

Parameters:
WIDTH, 16, output word width in bits; legal values 8, 16, 32, 64 (elaboration error otherwise)
STATE_W, 1600, Keccak state width; fixed, must be 1600

Ports:
ACLK  in  1  clock, rising edge
ARESETn  in  1  asynchronous active-low reset
s_state  in  1600  Keccak state; lane (x,y) at bits [64*(x+5y) +: 64]; byte 0 of a lane is bits [7:0]
s_id  in  2  0=SHA3-224, 1=SHA3-256, 2=SHA3-384, 3=SHA3-512
s_valid  in  1  state valid
s_ready  out  1  streamer can capture
m_data  out  WIDTH  digest word; first digest byte in MSBs
m_keep  out  WIDTH/8  byte-valid strobe; m_keep[i] covers m_data[8i+7:8i]
m_last  out  1  final word of the digest
m_id  out  2  latched s_id for the hash in flight
m_valid  out  1  m_data valid
m_ready  in  1  downstream accepts the word

Behaviour:
- Reset (async assert, sync release): state=IDLE; m_valid=0, m_last=0, m_data=0, m_keep=0, m_id=0, word counter=0; s_ready=1 after reset is released.
- Digest bytes NB by ID: 28/32/48/64. Digest byte k is byte (k mod 8) of lane k/8, taking lanes in index order 0..7.
- Words NW = ceil(NB/(WIDTH/8)):
  - WIDTH=16: 14/16/24/32
  - WIDTH=64: 4/4/6/8
- States:
  - IDLE: s_ready=1, m_valid=0. On s_valid&&s_ready, latch s_state into the capture register, latch s_id into m_id, clear the counter and go to STREAM.
  - STREAM: m_valid=1, with m_data = word[cnt]. On m_valid&&m_ready, cnt++.
  - On the handshake where cnt==NW-1 (m_last=1), return to IDLE unless a back-to-back capture occurs.
- Capture latency: 1 cycle. Word 0 is on m_data with m_valid=1 on the first edge after capture.
- Word packing: word w holds digest bytes w*B .. w*B+B-1 (B=WIDTH/8). Byte w*B sits in m_data[WIDTH-1 -: 8], descending from there.
- m_keep:
  - All ones on every word except a partial last word.
  - On a partial last word, only the upper valid bytes are set; invalid bytes are driven 0. Example: WIDTH=64, SHA3-224 last word m_keep=8'hF0.
- Backpressure:
  - While m_valid&&!m_ready, m_data, m_keep, m_last and m_id hold stable.
  - m_valid never drops before the handshake.
- Back-to-back: s_ready = (state==IDLE) || (m_valid && m_ready && m_last). A capture on the same edge as the last-word handshake goes straight to STREAM with cnt=0 and the new m_id, with no bubble.
- s_valid while busy: not captured. s_state and s_id must be held by the source until s_ready.
- Reset mid-stream: all outputs clear immediately and the in-flight digest is discarded.
- The counter is sized to $clog2(1600/8 + 1) bits; no wrap beyond NW-1.

Optional Feature:
SHA3_STREAM_FULL_STATE_EN
- Defined:
  - Adds input port s_full (1 bit), sampled with s_valid.
  - s_full=1 streams the entire 200-byte state in the same byte order: NW = 200/B (WIDTH=16 → 100 words), m_keep all ones on every word.
  - s_id is still latched.
- Undefined: port s_full is absent and only the digest length is ever streamed.

Test Plan:
- WIDTH=16, SHA3-256 empty-message state with lane0=64'h66d71ebff8c6ffa7 and the rest of the correct state, m_ready=1 -> 16 words: first 16'ha7ff, last 16'h434a with m_last=1. The concatenation equals a7ffc6f8bf1ed76651c14756a061d662f580ff4de43b49fa82d80a4b80f8434a.
- WIDTH=64, SHA3-224 empty-message state -> 4 words; word3 upper 32 bits = 32'h5b5a6bc7, m_keep=8'hF0, m_last=1; words 0-2 m_keep=8'hFF.
- Backpressure: m_ready toggled 1 cycle on / 2 off during a SHA3-512 stream at WIDTH=16 -> exactly 32 handshakes, outputs stable during stalls, no word dropped or duplicated.
- Back-to-back: s_valid held with ID=3 while ID=1 is finishing -> capture on the last-word handshake edge; next cycle m_valid=1, m_id=3, word 0 of the new digest, zero idle cycles.
- Reset mid-stream: ARESETn=0 at word 5 -> m_valid, m_last, m_keep and m_data = 0 in the same cycle. After release, s_ready=1, and a new capture streams from word 0.
- With SHA3_STREAM_FULL_STATE_EN, s_full=1, WIDTH=32 -> 50 words with m_last only on word 49.
